// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: double-buffered 8x8 LED frame store.
// Two requesters write rows into the back buffer through a round-robin arbiter.
// A commit waits for the scanner's frame_sync, or for a timeout, then swaps
// the buffers. The new back buffer is then refreshed from the displayed frame
// so requesters can keep editing incrementally.
module led_frame_ctrl #(
    parameter int unsigned SYNC_TIMEOUT = 40000,
    parameter int unsigned TO_W         = 16
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            wr0_valid,
    input  logic [2:0]      wr0_row,
    input  logic [7:0]      wr0_data,
    input  logic            wr1_valid,
    input  logic [2:0]      wr1_row,
    input  logic [7:0]      wr1_data,
    output logic            wr0_ready,
    output logic            wr1_ready,
    input  logic            commit,
    input  logic            frame_sync,
    output logic [7:0][7:0] matdata,
    output logic            busy,
    output logic            swap_done,
    output logic [7:0]      frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SWAP = 2'd2,
        ST_COPY = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [2:0]      idx_q, idx_d;
    logic            front_q, front_d;   // 0: buffer A is displayed
    logic            last_q, last_d;     // 1: requester 1 was granted most recently
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0][7:0] buf_a_q, buf_a_d;
    logic [7:0][7:0] buf_b_q, buf_b_d;

    logic [7:0][7:0] front_v, back_v, back_d;
    logic            gnt0, gnt1;

    assign front_v   = front_q ? buf_b_q : buf_a_q;
    assign back_v    = front_q ? buf_a_q : buf_b_q;
    assign matdata   = front_v;
    assign busy      = (state_q != ST_IDLE);
    assign swap_done = (state_q == ST_COPY) && (idx_q == 3'd0);
    assign frame_cnt = cnt_q;
    assign wr0_ready = gnt0;
    assign wr1_ready = gnt1;

    // Round-robin grant: only in IDLE, and never while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (nrst && (state_q == ST_IDLE)) begin
            if (wr0_valid && wr1_valid) begin
                if (last_q) gnt0 = 1'b1;
                else        gnt1 = 1'b1;
            end else begin
                gnt0 = wr0_valid;
                gnt1 = wr1_valid;
            end
        end
    end

    // Next-state logic: sequencing, back-buffer writes and copy-back.
    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        idx_d   = idx_q;
        front_d = front_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        back_d  = back_v;
        case (state_q)
            ST_IDLE: begin
                if (gnt0) begin
                    back_d[wr0_row] = wr0_data;
                    last_d          = 1'b0;
                end else if (gnt1) begin
                    back_d[wr1_row] = wr1_data;
                    last_d          = 1'b1;
                end
                if (commit) begin
                    state_d = ST_PEND;
                    to_d    = '0;
                end
            end
            ST_PEND: begin
                to_d = to_q + TO_W'(1);
                if (frame_sync || (to_q == TO_W'(SYNC_TIMEOUT - 1))) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                front_d = ~front_q;
                cnt_d   = cnt_q + 8'd1;
                idx_d   = '0;
                state_d = ST_COPY;
            end
            ST_COPY: begin
                back_d[idx_q] = front_v[idx_q];
                idx_d         = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The back buffer is selected by the current front_q; in SWAP back_d is
    // unchanged, so toggling front_q at the same edge is safe.
    always_comb begin
        buf_a_d = front_q ? back_d  : buf_a_q;
        buf_b_d = front_q ? buf_b_q : back_d;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            to_q    <= '0;
            idx_q   <= '0;
            front_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            front_q <= front_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
        end
    end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Testbench for led_frame_ctrl: a frame-level reference model (displayed frame,
// edit frame, pending/post-swap cycle counts) checked against the DUT every
// cycle, with directed scenarios and literal expectations plus random traffic.
module tb_led_frame_ctrl;

    localparam int unsigned TO = 20;

    logic            clk = 1'b0;
    logic            nrst;
    logic            wr0_valid, wr1_valid;
    logic [2:0]      wr0_row, wr1_row;
    logic [7:0]      wr0_data, wr1_data;
    logic            wr0_ready, wr1_ready;
    logic            commit, frame_sync;
    logic [7:0][7:0] matdata;
    logic            busy, swap_done;
    logic [7:0]      frame_cnt;

    always #5 clk = ~clk;

    led_frame_ctrl #(.SYNC_TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .nrst(nrst),
        .wr0_valid(wr0_valid), .wr0_row(wr0_row), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_row(wr1_row), .wr1_data(wr1_data),
        .wr0_ready(wr0_ready), .wr1_ready(wr1_ready),
        .commit(commit), .frame_sync(frame_sync),
        .matdata(matdata), .busy(busy), .swap_done(swap_done),
        .frame_cnt(frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what is shown, what requesters are editing, and how many
    // cycles remain in the pending wait / swap+copy-back window.
    logic [7:0] m_disp [8];
    logic [7:0] m_edit [8];
    int         m_fcnt;
    bit         m_last1;
    bit         m_pend;
    int         m_wait;
    int         m_post;   // 9: swap cycle, 8..1: copy-back cycles, 0: idle

    task automatic m_reset();
        for (int r = 0; r < 8; r++) begin
            m_disp[r] = '0;
            m_edit[r] = '0;
        end
        m_fcnt = 0; m_last1 = 1'b1; m_pend = 1'b0; m_wait = 0; m_post = 0;
    endtask

    // One clock cycle: check outputs against the model, advance the model,
    // let the DUT take the posedge, return at the next negedge.
    task automatic tick();
        bit         e_busy, g0, g1;
        logic [63:0] e_mat;
        #1;
        if (!nrst) m_reset();
        e_busy = m_pend || (m_post > 0);
        g0 = 1'b0; g1 = 1'b0;
        if (nrst && !e_busy) begin
            if (wr0_valid && wr1_valid) begin
                if (m_last1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = wr0_valid; g1 = wr1_valid;
            end
        end
        for (int r = 0; r < 8; r++) e_mat[8*r +: 8] = m_disp[r];
        chk("wr0_ready", 64'(wr0_ready), 64'(g0));
        chk("wr1_ready", 64'(wr1_ready), 64'(g1));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("swap_done", 64'(swap_done), 64'(m_post == 8));
        chk("matdata", 64'(matdata), e_mat);
        chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt % 256));
        if (nrst) begin
            if (!e_busy) begin
                if (g0) begin m_edit[wr0_row] = wr0_data; m_last1 = 1'b0; end
                else if (g1) begin m_edit[wr1_row] = wr1_data; m_last1 = 1'b1; end
                if (commit) begin m_pend = 1'b1; m_wait = 0; end
            end else if (m_pend) begin
                if (frame_sync || (m_wait == int'(TO) - 1)) begin
                    m_pend = 1'b0; m_post = 9;
                end else begin
                    m_wait++;
                end
            end else if (m_post == 9) begin
                for (int r = 0; r < 8; r++) m_disp[r] = m_edit[r];
                m_fcnt = (m_fcnt + 1) % 256;
                m_post = 8;
            end else begin
                m_post--;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        wr0_row = '0; wr1_row = '0; wr0_data = '0; wr1_data = '0;
        commit = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    // Called right after the commit cycle; i=1 is the first pending cycle.
    // sync_at=0 means no frame_sync (timeout path).
    task automatic swap_seq(input int sync_at, output int sd_at, output int sd_cnt, output int idle_at);
        sd_at = 0; sd_cnt = 0; idle_at = 0;
        for (int i = 1; i <= 60; i++) begin
            frame_sync = (i == sync_at);
            if (swap_done) begin
                sd_cnt++;
                if (sd_at == 0) sd_at = i;
            end
            if (!busy) begin
                idle_at = i;
                break;
            end
            tick();
        end
        frame_sync = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sd_at, sd_cnt, idle_at;
        m_reset();
        idle_inputs();
        nrst = 1'b0;
        @(negedge clk);

        // Reset state, with requesters trying to write.
        wr0_valid = 1'b1; wr1_valid = 1'b1;
        #1;
        chk("rst_ready0", 64'(wr0_ready), 64'd0);
        chk("rst_ready1", 64'(wr1_ready), 64'd0);
        chk("rst_matdata", 64'(matdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        do_reset();

        // Single write, commit, frame_sync 5 cycles after commit.
        wr0_valid = 1'b1; wr0_row = 3'd3; wr0_data = 8'hA5;
        tick();
        wr0_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        swap_seq(5, sd_at, sd_cnt, idle_at);
        chk("single_swap_done_at", 64'(sd_at), 64'd7);
        chk("single_swap_done_cnt", 64'(sd_cnt), 64'd1);
        chk("single_busy_low_at", 64'(idle_at), 64'd15);
        chk("single_matdata", 64'(matdata), 64'h00000000_A5000000);
        chk("single_frame_cnt", 64'(frame_cnt), 64'd1);

        // Copy-back: commit with no writes keeps the frame.
        commit = 1'b1;
        tick();
        commit = 1'b0;
        swap_seq(3, sd_at, sd_cnt, idle_at);
        chk("copyback_matdata", 64'(matdata), 64'h00000000_A5000000);
        chk("copyback_frame_cnt", 64'(frame_cnt), 64'd2);

        // Ignored events: write during PEND, commit during COPY.
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr0_valid = 1'b1; wr0_row = 3'd5; wr0_data = 8'hFF;
        #1;
        chk("pend_wr0_ready", 64'(wr0_ready), 64'd0);
        tick();
        wr0_valid = 1'b0; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        commit = 1'b1;
        chk("copy_swap_done", 64'(swap_done), 64'd1);
        tick();
        commit = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        for (int i = 0; i < 10; i++) tick();
        chk("ignored_commit_busy", 64'(busy), 64'd0);
        chk("ignored_commit_cnt", 64'(frame_cnt), 64'd3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        swap_seq(2, sd_at, sd_cnt, idle_at);
        chk("ignored_write_matdata", 64'(matdata), 64'h00000000_A5000000);
        chk("ignored_write_cnt", 64'(frame_cnt), 64'd4);

        // Round-robin tie after reset: grants 0,1,0,1.
        do_reset();
        wr0_valid = 1'b1; wr0_row = 3'd0; wr0_data = 8'h01;
        wr1_valid = 1'b1; wr1_row = 3'd0; wr1_data = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 64'(wr0_ready), 64'(i % 2 == 0));
            chk("rr_ready1", 64'(wr1_ready), 64'(i % 2 == 1));
            tick();
        end
        wr0_valid = 1'b0; wr1_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        swap_seq(2, sd_at, sd_cnt, idle_at);
        chk("rr_matdata", 64'(matdata), 64'h00000000_00000002);

        // Timeout swap: no frame_sync.
        do_reset();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        swap_seq(0, sd_at, sd_cnt, idle_at);
        chk("timeout_swap_done_at", 64'(sd_at), 64'd22);
        chk("timeout_frame_cnt", 64'(frame_cnt), 64'd1);

        // Reset mid-copy at k=4, then a normal transaction.
        wr1_valid = 1'b1; wr1_row = 3'd1; wr1_data = 8'h77;
        tick();
        wr1_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0; frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        nrst = 1'b0;
        #1;
        chk("midcopy_rst_matdata", 64'(matdata), 64'd0);
        chk("midcopy_rst_busy", 64'(busy), 64'd0);
        chk("midcopy_rst_cnt", 64'(frame_cnt), 64'd0);
        tick();
        nrst = 1'b1;
        wr1_valid = 1'b1; wr1_row = 3'd7; wr1_data = 8'h3C;
        tick();
        wr1_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        swap_seq(1, sd_at, sd_cnt, idle_at);
        chk("after_rst_matdata", 64'(matdata), 64'h3C000000_00000000);
        chk("after_rst_cnt", 64'(frame_cnt), 64'd1);

        // Random traffic, including occasional resets and timeouts.
        for (int c = 0; c < 3000; c++) begin
            nrst       = ($urandom_range(0, 499) != 0);
            wr0_valid  = 1'($urandom_range(0, 1));
            wr1_valid  = 1'($urandom_range(0, 1));
            wr0_row    = 3'($urandom_range(0, 7));
            wr1_row    = 3'($urandom_range(0, 7));
            wr0_data   = 8'($urandom);
            wr1_data   = 8'($urandom);
            commit     = ($urandom_range(0, 15) == 0);
            frame_sync = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
            tick();
        end
        nrst = 1'b1;

        // frame_cnt wraps 255 -> 0.
        do_reset();
        for (int s = 0; s < 256; s++) begin
            commit = 1'b1;
            tick();
            commit = 1'b0; frame_sync = 1'b1;
            tick();
            frame_sync = 1'b0;
            for (int i = 0; i < 20 && busy; i++) tick();
        end
        chk("wrap_busy", 64'(busy), 64'd0);
        chk("wrap_frame_cnt", 64'(frame_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_frame_ctrl.md
LED_FRAME_CTRL -- requirements
Module: led_frame_ctrl

Interface
REQ-001 Parameter SYNC_TIMEOUT, default 40000: cycles spent in PEND without frame_sync before a forced swap.
REQ-002 Parameter TO_W, default 16: width of the timeout counter; SYNC_TIMEOUT SHALL be below 2^TO_W.
REQ-003 clk  in  1  clock; all state changes on posedge clk.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 wr0_valid, wr1_valid  in  1 each  write request from requester 0 and requester 1.
REQ-006 wr0_row, wr1_row  in  3 each  target row index, 0..7.
REQ-007 wr0_data, wr1_data  in  8 each  row pixel data; bit c is column c; 1 means lit.
REQ-008 wr0_ready, wr1_ready  out  1 each  write accepted this cycle.
REQ-009 commit  in  1  single-cycle pulse requesting a back-to-front buffer swap.
REQ-010 frame_sync  in  1  pulse from the matrix scanner marking a row 7->0 wrap.
REQ-011 matdata  out  8x8 packed  front buffer; matdata[r] is row r; driven directly from registers.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 swap_done  out  1  single-cycle pulse in the cycle after a swap.
REQ-014 frame_cnt  out  8  count of completed swaps; wraps 255->0.

Function
REQ-015 Storage: two 8x8 buffers, A and B, plus a front-select bit; the front buffer drives matdata and all writes target the back buffer.
REQ-016 States: IDLE, PEND, SWAP, COPY; any illegal encoding SHALL go to IDLE on the next cycle.
REQ-017 IDLE: writes accepted; commit=1 -> PEND; the timeout counter clears on entry to PEND.
REQ-018 PEND: no writes; the timeout counter increments each cycle; frame_sync=1 or counter==SYNC_TIMEOUT-1 -> SWAP.
REQ-019 SWAP: one cycle; toggle front-select at the clock edge that leaves SWAP; frame_cnt+1; -> COPY.
REQ-020 COPY: 8 cycles with index k=0..7; back row k <= front row k; no writes; after k=7 -> IDLE.
REQ-021 swap_done SHALL be high in the first COPY cycle only.
REQ-022 Net effect: the new back buffer equals the displayed frame, so requesters edit incrementally.
REQ-023 matdata SHALL change only at the SWAP-exit edge; it is never partially updated mid-frame.
REQ-024 Arbitration, IDLE only: at most one write per cycle.
REQ-025 Only one requester valid: that requester is granted.
REQ-026 Both valid: grant the requester not granted most recently.
REQ-027 The last-grant pointer updates only on an accepted write.
REQ-028 wrN_ready = (state==IDLE) AND granted(N); this is combinational, and valid SHALL NOT depend on ready.
REQ-029 Accepted write: back[wrN_row] <= wrN_data at that edge.
REQ-030 A write and commit in the same IDLE cycle: the write completes, then PEND.
REQ-031 commit outside IDLE SHALL be ignored and not queued.
REQ-032 frame_sync in IDLE, SWAP or COPY SHALL be ignored.
REQ-033 frame_sync and timeout in the same PEND cycle: exactly one swap.
REQ-034 busy SHALL be combinational from the state register.

Reset
REQ-035 nrst low SHALL immediately clear buffers A and B to 0, front-select to A, state to IDLE, timeout counter, COPY index and frame_cnt to 0.
REQ-036 Reset SHALL set the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-037 During reset, matdata=0, busy=0, swap_done=0 and both ready outputs are 0.
REQ-038 Reset asserted in any state, including mid-COPY, SHALL abort the operation with no residual effect after release.

Verification
REQ-039 Single write, commit, swap: after reset, wr0 row3=0xA5, then commit, then frame_sync 5 cycles later -> matdata[3]=0xA5, other rows 0, frame_cnt=1, swap_done one pulse, busy low 10 cycles after frame_sync.
REQ-040 Round-robin tie: both valid continuously, wr0 row0=0x01, wr1 row0=0x02, 4 cycles -> grants 0,1,0,1; after swap matdata[0]=0x02.
REQ-041 Copy-back: after swap with row3=0xA5, commit again with no writes -> matdata[3] still 0xA5, frame_cnt=2.
REQ-042 Timeout swap: SYNC_TIMEOUT=20, commit with no frame_sync -> SWAP entered exactly 20 cycles after entering PEND; frame_cnt=1.
REQ-043 Ignored events: commit during COPY, and wr0_valid during PEND -> wr0_ready=0, no second swap, back buffer unchanged.
REQ-044 Reset mid-COPY (k=4) -> matdata=0, state IDLE, frame_cnt=0 immediately; a normal write-commit-swap succeeds afterwards.
